// File: rtl/mem_pkg.sv
// Shared definitions for the block-fill reader and its neighbours on the
// 16-bit byte-addressed memory bus.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fill_state_e;

  localparam int WORD_BYTES     = 2;
  localparam int DEF_ADDR_WIDTH = 16;

endpackage

// File: rtl/fill_counter.sv
// Up-counter cleared to zero on request, with a flag that is high while the
// count equals LAST.
module fill_counter #(
  parameter int unsigned   W    = 4,
  parameter logic [W-1:0]  LAST = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_fill_ctrl.sv
// Cache-miss block fill: issues WORDS_PER_BLOCK back-to-back word reads and
// streams the returned words into the cache data array, then writes the tag.
module mem_fill_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_data_valid,
  output logic                  cache_wr_en,
  output logic [OFF_W-1:0]      cache_wr_word,
  output logic [15:0]           cache_wr_data,
  output logic                  tag_wr_en
);

  // One extra counter bit keeps the terminal compare unambiguous.
  localparam int                    CNT_W    = OFF_W + 1;
  localparam logic [CNT_W-1:0]      LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
    ~ADDR_WIDTH'(WORD_BYTES * WORDS_PER_BLOCK - 1);

  fill_state_e           state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      recv_cnt;
  logic                  issue_last;
  logic                  recv_last;
  logic                  start;
  logic                  issuing;
  logic                  receiving;
  logic                  recv_done;
  logic                  recv_cnt_msb_unused;

  assign start     = (state_q == IDLE) && miss_detected;
  assign issuing   = (state_q == ISSUE);
  assign receiving = (state_q != IDLE) && mem_data_valid;
  assign recv_done = receiving && recv_last;

  fill_counter #(.W(CNT_W), .LAST(LAST)) u_issue_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start),
    .inc_i  (issuing),
    .cnt_o  (issue_cnt),
    .term_o (issue_last)
  );

  fill_counter #(.W(CNT_W), .LAST(LAST)) u_recv_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start),
    .inc_i  (receiving),
    .cnt_o  (recv_cnt),
    .term_o (recv_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (miss_detected) state_q <= ISSUE;
        ISSUE: begin
          if (recv_done) begin
            state_q <= IDLE;
          end else if (issue_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN:   if (recv_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Block base is only ever observed while issuing, so it carries no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      base_q <= miss_address & BLK_MASK;
    end
  end

  assign fill_busy     = (state_q != IDLE);
  assign mem_enable    = issuing;
  assign mem_wr        = 1'b0;
  assign mem_addr      = issuing ?
    base_q + {{(ADDR_WIDTH-CNT_W-1){1'b0}}, issue_cnt, 1'b0} : '0;
  assign cache_wr_en   = receiving;
  assign cache_wr_word = recv_cnt[OFF_W-1:0];
  assign cache_wr_data = receiving ? mem_rdata : '0;
  assign tag_wr_en     = recv_done;
  assign fill_done     = recv_done;

  assign recv_cnt_msb_unused = recv_cnt[OFF_W];

`ifndef SYNTHESIS
  // The memory cannot return the final word before it has been requested.
  a_no_early_last: assert property (@(posedge clk) disable iff (!rst_n)
    !(issuing && recv_done));
`endif

endmodule

// File: doc/mem_fill_ctrl.md
Name: mem_fill_ctrl

Overview:
- Initiator-side reader for the byte-addressed 16-bit memory. On a cache miss it fetches one aligned block as WORDS_PER_BLOCK sequential word reads.
- Works with a pipelined multi-cycle memory that accepts one request per cycle and returns data with a valid strobe.
- Streams returned words into the cache data array, then writes the tag. Sits between cache control and the memory.

Parameters:
ADDR_WIDTH, 16, byte-address width; word addresses always have bit 0 = 0
WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two, at least 2
OFF_W, $clog2(WORDS_PER_BLOCK), word-offset counter width (derived)

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
miss_detected  in  1  level; cache requests a fill
miss_address  in  ADDR_WIDTH  byte address of the missing access
fill_busy  out  1  high from the first issue cycle through the final word write
fill_done  out  1  one-cycle pulse when the block is complete
mem_enable  out  1  memory request strobe
mem_wr  out  1  constant 0 (read-only initiator)
mem_addr  out  ADDR_WIDTH  request byte address
mem_rdata  in  16  returned memory data
mem_data_valid  in  1  mem_rdata is valid this cycle
cache_wr_en  out  1  write mem_rdata into the cache data array
cache_wr_word  out  OFF_W  word offset within the block for cache_wr_en
cache_wr_data  out  16  equals mem_rdata
tag_wr_en  out  1  write tag/valid for the block; one-cycle pulse

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE and both counters=0. All outputs are 0, including mem_addr and cache_wr_word.
- base = miss_address with the low (OFF_W+1) bits cleared, captured in the cycle miss_detected is sampled in IDLE.
- States: IDLE, ISSUE, DRAIN.
- IDLE: miss_detected=1 -> latch base, issue_cnt=0, recv_cnt=0, go to ISSUE. The first request appears the next cycle.
- ISSUE, every cycle:
  - mem_enable=1, mem_addr = base + 2*issue_cnt, issue_cnt++.
  - After issuing WORDS_PER_BLOCK-1, go to DRAIN.
  - Exactly WORDS_PER_BLOCK consecutive requests, no gaps.
- ISSUE and DRAIN: each mem_data_valid=1 produces cache_wr_en=1 combinationally that same cycle, with cache_wr_word=recv_cnt and cache_wr_data=mem_rdata; then recv_cnt++.
- Completion: when mem_data_valid=1 and recv_cnt==WORDS_PER_BLOCK-1, the same cycle also asserts tag_wr_en=1 and fill_done=1. Next state is IDLE.
- Early return: valid data can arrive while still in ISSUE; receive is independent of issue. If the last word arrives in ISSUE, an error assertion fires (memory can't answer before being asked).
- fill_busy = (state != IDLE).
- miss_detected while busy: ignored; miss_address changes mid-fill are ignored.
- mem_data_valid in IDLE: ignored; no cache or tag write.
- Back-to-back misses: if miss_detected is still high the cycle after fill_done, a new fill starts. The cache deasserts miss on the tag write.
- Counter wrap: counters are OFF_W+1 bits wide so the terminal compare is unambiguous; no wrap occurs within a fill.
- Reset mid-fill: abandon immediately and return to IDLE. In-flight memory returns after reset are ignored as IDLE valids.
- mem_wr=0 in every state.

Decomposition:
- Shared package mem_pkg: state enum (IDLE/ISSUE/DRAIN), WORD_BYTES=2, and a default ADDR_WIDTH constant shared with the memory and cache.
- One natural sub-module, fill_counter: a loadable up-counter with a terminal flag, instantiated twice (issue and receive).
- The FSM and output decode stay in mem_fill_ctrl.

Test Plan:
- Basic fill: memory model with 4-cycle latency; miss_address=0x1236 at cycle N.
  - Requests 0x1230, 0x1232, …, 0x123E on cycles N+1 to N+8.
  - cache_wr_word 0 to 7 on cycles N+5 to N+12.
  - tag_wr_en and fill_done on cycle N+12; fill_busy high N+1 to N+12.
- Variable latency: memory returns with random 1–6 cycle gaps. All 8 words are written in order with the correct data, with exactly one done pulse.
- Ignored inputs: miss_detected toggled and miss_address changed to 0xFFF0 mid-fill; stray mem_data_valid pulses in IDLE.
  - The original block completes unchanged.
  - No cache_wr_en appears while IDLE.
- Reset mid-fill: rst_n=0 for 1 cycle after the 3rd returned word.
  - All outputs drop to 0 asynchronously.
  - Late valids cause no writes.
  - A new miss at 0x0000 then completes normally.
- Back-to-back: miss_detected held high through the first fill. A second fill of the same base starts on the cycle after fill_done.
- Parameter sweep: WORDS_PER_BLOCK=4, miss 0xABCE -> requests 0xABC8 to 0xABCE, 4 cache writes, done on the 4th return.
